clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Activity-driven controller that generates the enable for the latch-based clock gate `gated_clk`. It counts consecutive idle cycles of a gated domain, drops the enable to gate the clock, and re-enables it on a wake request. After a wake it holds `ready` low until the clock has run for a fixed number of cycles. It runs on the free-running clock and its `en` output feeds the `en` input of the gate.

## Interface
- IDLE_CYCLES, 16: consecutive idle cycles required before gating; must be ≥1.
- WAKE_CYCLES, 2: cycles of running clock after a wake before `ready` rises; must be ≥1.
- CNT_W, 8: internal counter width; must satisfy 2^CNT_W > max(IDLE_CYCLES, WAKE_CYCLES).
- c  in  1  free-running clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- busy  in  1  activity from the gated domain; 1 = work pending.
- wake_req  in  1  external wake request, level-sensitive.
- sleep_allow  in  1  0 forbids gating (software override).
- en  out  1  enable to `gated_clk`; 1 = clock runs.
- ready  out  1  gated domain clock running and stable.
- gated  out  1  status; 1 while the clock is gated.
- gate_cnt  out  16  number of gating events, saturating.

## Operation
- States: RUN, DRAIN, GATED, WAKE. All outputs are registered and decoded from the state register.
- Outputs per state:
  - RUN: en=1, ready=1, gated=0.
  - DRAIN: en=1, ready=0, gated=0.
  - GATED: en=0, ready=0, gated=1.
  - WAKE: en=1, ready=0, gated=0.
- Idle condition: idle = sleep_allow & ~busy & ~wake_req.
- RUN:
  - idle_cnt increments on each idle cycle and clears to 0 on any non-idle cycle.
  - If idle_cnt == IDLE_CYCLES-1 and the cycle is idle, go to DRAIN.
- DRAIN (exactly one cycle):
  - If idle still holds, go to GATED and increment gate_cnt (saturates at 0xFFFF).
  - Otherwise abort to RUN with idle_cnt=0. gate_cnt is unchanged.
- GATED:
  - busy | wake_req | ~sleep_allow moves to WAKE with wake_cnt=0.
  - Otherwise stay in GATED.
- WAKE:
  - wake_cnt increments every cycle.
  - When wake_cnt == WAKE_CYCLES-1, go to RUN with idle_cnt=0.
  - busy, wake_req and sleep_allow are ignored in WAKE; no re-gating before reaching RUN.
- Reset (rst_n=0, asynchronous, including mid-operation):
  - state=WAKE, wake_cnt=0, idle_cnt=0, gate_cnt=0.
  - en=1 immediately, so the clock is never left gated while in reset.
  - ready=0, gated=0.
  - After release, follows normal WAKE sequencing.

## Timing
- Gating latency:
  - busy first sampled low at edge k, with sleep_allow=1 and wake_req=0 held.
  - DRAIN is entered at edge k+IDLE_CYCLES-1; ready falls at that edge.
  - en falls at edge k+IDLE_CYCLES. gated rises and gate_cnt increments at the same edge.
- Wake latency:
  - Wake condition sampled at edge m in GATED.
  - en=1 and gated=0 from edge m.
  - ready=1 from edge m+WAKE_CYCLES.
- en changes only on a rising edge of c, so it is stable while c is low. This satisfies the gate latch's transparent-low sampling; the first gated pulse is suppressed or restored cleanly.
- Release of rst_n has no minimum spacing requirement. The first rising edge after release counts as WAKE cycle 0.
- Simultaneous events:
  - busy and wake_req together in GATED: single transition to WAKE.
  - busy returning in the DRAIN cycle: abort wins, and en never falls.
  - sleep_allow=0 in RUN: idle_cnt held at 0.

## Test plan
All cases use IDLE_CYCLES=16 and WAKE_CYCLES=2.
- Reset, then release rst_n: en=1 and ready=0 during reset. ready=1 at the 2nd rising edge after release. gated=0, gate_cnt=0.
- busy low from edge 10, sleep_allow=1: ready=0 at edge 25, en=0 and gated=1 at edge 26, gate_cnt=1. The clock into `gated_clk` shows no pulses after edge 26.
- In GATED, wake_req pulsed high for 1 cycle at edge 40: en=1 at 40, ready=1 at 42, state RUN. Holding busy=1 afterwards keeps en=1 indefinitely.
- busy low for 15 cycles then high 1 cycle, repeated: en never falls, gate_cnt stays 0. busy rising exactly in the DRAIN cycle: ready returns to 1 next edge, en stays 1.
- sleep_allow=0 with busy=0 for 100 cycles: en=1 throughout. sleep_allow dropped while GATED: wake sequence runs and ready=1 two edges later.
- Force gate_cnt to 0xFFFE via 65534 gate/wake cycles (or a backdoor preload), then gate twice: gate_cnt reads 0xFFFF and stays there. Assert rst_n low while GATED: en=1 asynchronously before the next edge, gate_cnt=0.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Purpose  : Idle-count clock-gate enable controller with wake/ready sequencing
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        busy,
    input  logic        wake_req,
    input  logic        sleep_allow,
    output logic        en,
    output logic        ready,
    output logic        gated,
    output logic [15:0] gate_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_GATED = 2'd2,
        S_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [15:0]      C_CNT_MAX   = 16'hFFFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_wake_cnt;
    logic [15:0]      r_gate_cnt;
    logic             r_en;
    logic             r_ready;
    logic             r_gated;
    logic             w_idle;
    logic             w_gate_evt;

    assign w_idle     = sleep_allow & ~busy & ~wake_req;
    assign w_gate_evt = (r_state == S_DRAIN) && (w_state_nxt == S_GATED);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_idle && (r_idle_cnt == C_IDLE_LAST)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = w_idle ? S_GATED : S_RUN;
            end
            S_GATED: begin
                if (!w_idle) begin
                    w_state_nxt = S_WAKE;
                end
            end
            S_WAKE: begin
                if (r_wake_cnt == C_WAKE_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_WAKE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register; reset holds en high so the clock never stays gated.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAKE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_gate_cnt <= '0;
            r_en       <= 1'b1;
            r_ready    <= 1'b0;
            r_gated    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && w_idle) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end

            if ((r_state == S_WAKE) && (w_state_nxt == S_WAKE)) begin
                r_wake_cnt <= r_wake_cnt + 1'b1;
            end else begin
                r_wake_cnt <= '0;
            end

            if (w_gate_evt && (r_gate_cnt != C_CNT_MAX)) begin
                r_gate_cnt <= r_gate_cnt + 16'd1;
            end

            r_en    <= (w_state_nxt != S_GATED);
            r_ready <= (w_state_nxt == S_RUN);
            r_gated <= (w_state_nxt == S_GATED);
        end
    end

    assign en       = r_en;
    assign ready    = r_ready;
    assign gated    = r_gated;
    assign gate_cnt = r_gate_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Purpose  : Self-checking bench for clk_gate_ctrl against a streak-based model
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int IDLE = 16;
    localparam int WAKE = 2;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy = 1'b1;
    logic        wake_req = 1'b0;
    logic        sleep_allow = 1'b1;
    logic        en;
    logic        ready;
    logic        gated;
    logic [15:0] gate_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    clk_gate_ctrl #(
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .CNT_W       (8)
    ) dut (
        .c           (c),
        .rst_n       (rst_n),
        .busy        (busy),
        .wake_req    (wake_req),
        .sleep_allow (sleep_allow),
        .en          (en),
        .ready       (ready),
        .gated       (gated),
        .gate_cnt    (gate_cnt)
    );

    always #5 c = ~c;

    // Reference: the clock gates after IDLE+1 consecutive idle edges while
    // running; any wake costs WAKE edges of running clock before ready.
    bit m_gated;
    int m_wake_left;
    int m_streak;
    int m_events;

    always @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            m_gated     = 1'b0;
            m_wake_left = WAKE;
            m_streak    = 0;
            m_events    = 0;
        end else if (m_gated) begin
            if (!(sleep_allow && !busy && !wake_req)) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left = m_wake_left - 1;
            m_streak    = 0;
        end else if (sleep_allow && !busy && !wake_req) begin
            m_streak = m_streak + 1;
            if (m_streak > IDLE) begin
                m_gated  = 1'b1;
                m_streak = 0;
                m_events = m_events + 1;
            end
        end else begin
            m_streak = 0;
        end
    end

    function automatic logic [18:0] exp_vec();
        int s;
        s = base + m_events;
        if (s > 65535) s = 65535;
        return {!m_gated, (!m_gated && m_wake_left == 0 && m_streak < IDLE), m_gated, 16'(s)};
    endfunction

    task automatic tick();
        @(negedge c);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; busy = 1'b1; wake_req = 1'b0; sleep_allow = 1'b1; base = 0;
        tick(); tick();
        total++;
        if ({en, ready, gated, gate_cnt} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", {en, ready, gated, gate_cnt}, {3'b100, 16'h0});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (ready !== 1'b0 || en !== 1'b1) begin
            bad++; $display("FAIL reset_edge1 ready=%b en=%b exp ready=0 en=1", ready, en);
        end
        tick();
        total++;
        if ({en, ready, gated, gate_cnt} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
            bad++; $display("FAIL reset_edge2 got=%h exp=%h", {en, ready, gated, gate_cnt}, {3'b110, 16'h0});
        end
    endtask

    task automatic test_gating();
        tick();
        busy = 1'b0;
        for (int j = 0; j <= IDLE; j++) begin
            tick();
            total++;
            if ({en, ready, gated, gate_cnt} !== exp_vec()) begin
                bad++; $display("FAIL gating_model j=%0d got=%h exp=%h", j, {en, ready, gated, gate_cnt}, exp_vec());
            end
            if (j == IDLE - 1) begin
                total++;
                if (ready !== 1'b0 || en !== 1'b1) begin
                    bad++; $display("FAIL gating_drain ready=%b en=%b exp ready=0 en=1", ready, en);
                end
            end
        end
        total++;
        if ({en, gated, gate_cnt} !== {1'b0, 1'b1, 16'd1}) begin
            bad++; $display("FAIL gating_gated got=%h exp=%h", {en, gated, gate_cnt}, {2'b01, 16'd1});
        end
    endtask

    task automatic test_wake();
        for (int j = 0; j < 5; j++) begin
            tick();
            total++;
            if (en !== 1'b0 || gated !== 1'b1) begin
                bad++; $display("FAIL wake_stay j=%0d en=%b gated=%b exp en=0 gated=1", j, en, gated);
            end
        end
        wake_req = 1'b1;
        tick();
        total++;
        if ({en, ready, gated} !== 3'b100) begin
            bad++; $display("FAIL wake_m got=%b exp=100", {en, ready, gated});
        end
        wake_req = 1'b0; busy = 1'b1;
        tick();
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL wake_m1 ready=%b exp=0", ready);
        end
        tick();
        total++;
        if (ready !== 1'b1 || en !== 1'b1) begin
            bad++; $display("FAIL wake_m2 ready=%b en=%b exp 1 1", ready, en);
        end
        for (int j = 0; j < 30; j++) begin
            tick();
            total++;
            if (en !== 1'b1 || {en, ready, gated, gate_cnt} !== exp_vec()) begin
                bad++; $display("FAIL wake_busy j=%0d got=%h exp=%h", j, {en, ready, gated, gate_cnt}, exp_vec());
            end
        end
    endtask

    task automatic test_abort();
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 16; j++) begin
                busy = (j == 15);
                tick();
                total++;
                if (en !== 1'b1 || gate_cnt !== 16'd1 || {en, ready, gated, gate_cnt} !== exp_vec()) begin
                    bad++; $display("FAIL abort_pattern r=%0d j=%0d got=%h exp=%h", r, j, {en, ready, gated, gate_cnt}, exp_vec());
                end
            end
        end
        busy = 1'b0;
        for (int j = 0; j < IDLE; j++) tick();
        total++;
        if (ready !== 1'b0 || en !== 1'b1) begin
            bad++; $display("FAIL abort_drain ready=%b en=%b exp 0 1", ready, en);
        end
        busy = 1'b1;
        tick();
        total++;
        if ({en, ready, gated, gate_cnt} !== {3'b110, 16'd1}) begin
            bad++; $display("FAIL abort_return got=%h exp=%h", {en, ready, gated, gate_cnt}, {3'b110, 16'd1});
        end
        tick();
        total++;
        if (en !== 1'b1) begin
            bad++; $display("FAIL abort_after en=%b exp=1", en);
        end
    endtask

    task automatic test_sleep_override();
        sleep_allow = 1'b0; busy = 1'b0;
        for (int j = 0; j < 100; j++) begin
            tick();
            total++;
            if (en !== 1'b1 || {en, ready, gated, gate_cnt} !== exp_vec()) begin
                bad++; $display("FAIL override_hold j=%0d got=%h exp=%h", j, {en, ready, gated, gate_cnt}, exp_vec());
            end
        end
        sleep_allow = 1'b1;
        for (int j = 0; j <= IDLE; j++) tick();
        total++;
        if (gated !== 1'b1 || en !== 1'b0) begin
            bad++; $display("FAIL override_gate gated=%b en=%b exp 1 0", gated, en);
        end
        sleep_allow = 1'b0;
        tick();
        total++;
        if ({en, ready, gated} !== 3'b100) begin
            bad++; $display("FAIL override_wake got=%b exp=100", {en, ready, gated});
        end
        tick(); tick();
        total++;
        if (ready !== 1'b1) begin
            bad++; $display("FAIL override_ready ready=%b exp=1", ready);
        end
        sleep_allow = 1'b1; busy = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        force dut.r_gate_cnt = 16'hFFFE;
        base = 65534 - m_events;
        #1;
        release dut.r_gate_cnt;
        for (int g = 0; g < 2; g++) begin
            busy = 1'b0;
            for (int j = 0; j <= IDLE; j++) tick();
            total++;
            if (gated !== 1'b1 || gate_cnt !== 16'hFFFF) begin
                bad++; $display("FAIL saturate g=%0d gated=%b cnt=%h exp 1 ffff", g, gated, gate_cnt);
            end
            busy = 1'b1;
            for (int j = 0; j < 3; j++) tick();
            total++;
            if ({en, ready, gated, gate_cnt} !== exp_vec()) begin
                bad++; $display("FAIL saturate_wake g=%0d got=%h exp=%h", g, {en, ready, gated, gate_cnt}, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        busy = 1'b0;
        for (int j = 0; j <= IDLE + 2; j++) tick();
        total++;
        if (gated !== 1'b1) begin
            bad++; $display("FAIL async_pre gated=%b exp=1", gated);
        end
        #2;
        base  = 0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({en, ready, gated, gate_cnt} !== {3'b100, 16'h0000}) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", {en, ready, gated, gate_cnt}, {3'b100, 16'h0});
        end
        tick();
        rst_n = 1'b1; busy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            total++;
            if ({en, ready, gated, gate_cnt} !== exp_vec()) begin
                bad++; $display("FAIL async_release j=%0d got=%h exp=%h", j, {en, ready, gated, gate_cnt}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            tick();
            total++;
            if ({en, ready, gated, gate_cnt} !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {en, ready, gated, gate_cnt}, exp_vec());
            end
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                #2;
                base  = 0;
                rst_n = 1'b0;
                #1;
                total++;
                if ({en, ready, gated, gate_cnt} !== {3'b100, 16'h0000}) begin
                    bad++; $display("FAIL random_reset cyc=%0d got=%h", cyc, {en, ready, gated, gate_cnt});
                end
            end
            busy        = ($urandom_range(0, 19) == 0);
            wake_req    = ($urandom_range(0, 49) == 0);
            sleep_allow = ($urandom_range(0, 39) != 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_gating();
        test_wake();
        test_abort();
        test_sleep_override();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
